// File: rtl/add_serial_ctrl.sv
// Sequencer for the bit-serial adder: queues operand pairs, issues them,
// captures each sum and presents it on a valid/ready result port.
module add_serial_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int ADD_LAT = 9,
    parameter int CNT_W   = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int LW     = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_en,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic [LW-1:0]    fifo_level
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_REL
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic full;
    logic push;
    logic pop;
    logic capture;
    logic add_en_d;
    logic slot_free;
    logic at_lat;

    assign full      = (fifo_level == LW'(DEPTH));
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign slot_free = !res_valid || res_ready;
    assign at_lat    = (cnt_q == CNT_W'(ADD_LAT));
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        capture  = 1'b0;
        add_en_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fifo_level != '0) begin
                    pop      = 1'b1;
                    add_en_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                // Count saturates at ADD_LAT while the result slot is busy.
                if (!at_lat) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (slot_free) begin
                    capture  = 1'b1;
                    add_en_d = 1'b1;
                    state_d  = S_REL;
                end
            end
            S_REL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            add_en  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            add_en  <= add_en_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a <= '0;
            add_b <= '0;
        end else if (pop) begin
            add_a <= mem_a[rd_ptr];
            add_b <= mem_b[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= add_out;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Bench for add_serial_ctrl: behavioural adder, transaction scoreboard
// and directed scenarios with hand-computed expectations.
module tb_add_serial_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int ADD_LAT = 9;
    localparam int CNT_W   = 4;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             add_en;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic [LW-1:0]    fifo_level;

    add_serial_ctrl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_LAT(ADD_LAT), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .add_en(add_en), .add_a(add_a), .add_b(add_b),
        .add_out(add_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Behavioural adder: sum appears ADD_LAT cycles after the start cycle,
    // then held until the next enable returns it to idle.
    int               ad_st;
    int               ad_k;
    logic [WIDTH-1:0] ad_sum;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad_st   <= 0;
            ad_k    <= 0;
            ad_sum  <= '0;
            add_out <= '0;
        end else begin
            case (ad_st)
                0: if (add_en) begin
                    ad_st   <= 1;
                    ad_k    <= 1;
                    ad_sum  <= WIDTH'(add_a + add_b);
                    add_out <= ~WIDTH'(add_a + add_b);
                end
                1: begin
                    ad_k <= ad_k + 1;
                    if (ad_k + 1 == ADD_LAT) begin
                        ad_st   <= 2;
                        add_out <= ad_sum;
                    end
                end
                default: if (add_en) ad_st <= 0;
            endcase
        end
    end

    // Transaction model: pairs waiting, pairs issued, sums not yet read.
    logic [2*WIDTH-1:0] pend_q[$];
    logic [2*WIDTH-1:0] iss_q[$];
    logic [WIDTH-1:0]   res_q[$];
    int                 exp_level = 0;

    int               start_q[$];
    int               rel_q[$];
    int               rise_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic             prev_en = 1'b0;
    logic             prev_rv = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            iss_q.delete();
            res_q.delete();
            exp_level = 0;
            prev_en = 1'b0;
            prev_rv = 1'b0;
        end else begin
            chk("level", int'(fifo_level), exp_level);
            chk("in_ready", int'(in_ready), int'(exp_level < DEPTH));
            if (add_en && prev_en) chk("en_twice", 1, 0);
            if (add_en && ad_st == 1) chk("en_in_run", 1, 0);
            if (add_en && ad_st == 0) begin
                start_q.push_back(cyc);
                chk("start_busy", int'(busy), 1);
                if (iss_q.size() == 0) begin
                    chk("start_unexpected", 1, 0);
                end else begin
                    chk("issue_pair", int'({add_a, add_b}), int'(iss_q[0]));
                    res_q.push_back(WIDTH'(iss_q[0][2*WIDTH-1:WIDTH]
                                           + iss_q[0][WIDTH-1:0]));
                    void'(iss_q.pop_front());
                end
            end
            if (add_en && ad_st == 2) rel_q.push_back(cyc);
            if (res_valid && !prev_rv) rise_q.push_back(cyc);
            if (res_valid) begin
                if (res_q.size() == 0) begin
                    chk("res_unexpected", 1, 0);
                end else begin
                    chk("res_data", int'(res_data), int'(res_q[0]));
                    if (res_ready) begin
                        got_q.push_back(res_data);
                        void'(res_q.pop_front());
                    end
                end
            end
            if (!busy && exp_level > 0) begin
                iss_q.push_back(pend_q.pop_front());
                exp_level--;
            end
            if (in_valid && in_ready) begin
                pend_q.push_back({in_a, in_b});
                exp_level++;
            end
            prev_en = add_en;
            prev_rv = res_valid;
        end
    end

    task automatic clear_rec();
        start_q.delete();
        rel_q.delete();
        rise_q.delete();
        got_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int n);
        logic r;
        int   guard;
        guard = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        forever begin
            r = in_ready;
            @(posedge clk);
            #1;
            if (r) break;
            guard++;
            if (guard > 200) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
        n = cyc;
    endtask

    task automatic chk_got(input string name, input int idx, input int exp);
        if (got_q.size() <= idx) chk({name, "_missing"}, got_q.size(), idx + 1);
        else chk(name, int'(got_q[idx]), exp);
    endtask

    initial begin
        int n, m, guard;
        logic [WIDTH-1:0] exp_b2b[5];
        exp_b2b = '{8'h00, 8'h03, 8'h30, 8'h80, 8'hFF};

        #1;
        chk("rst_add_en", int'(add_en), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Single op: timing of start, release and result.
        clear_rec();
        push(8'h35, 8'h4A, n);
        tick(20);
        chk("t1_starts", start_q.size(), 1);
        chk("t1_start_cyc", start_q[0], n + 1);
        chk("t1_rel_cyc", rel_q[0], n + 1 + ADD_LAT + 1);
        chk("t1_rise_cyc", rise_q[0], n + 1 + ADD_LAT + 1);
        chk_got("t1_sum", 0, 'h7F);

        // Carry dropped.
        clear_rec();
        push(8'hFF, 8'h01, n);
        tick(16);
        chk_got("t2_sum", 0, 'h00);

        // Fill the FIFO behind an in-flight op.
        clear_rec();
        push(8'h80, 8'h80, n);
        push(8'h01, 8'h02, n);
        push(8'h10, 8'h20, n);
        push(8'h7F, 8'h01, n);
        push(8'hAA, 8'h55, n);
        chk("t3_level_full", int'(fifo_level), 4);
        in_valid = 1'b1;
        in_a = 8'h00;
        in_b = 8'h00;
        chk("t3_in_ready_full", int'(in_ready), 0);
        tick(1);
        in_valid = 1'b0;
        tick(70);
        chk("t3_count", got_q.size(), 5);
        for (int i = 0; i < 5; i++) chk_got("t3_sum", i, int'(exp_b2b[i]));
        for (int i = 1; i < 5; i++)
            if (start_q.size() > i)
                chk("t3_spacing", start_q[i] - start_q[i-1], ADD_LAT + 3);

        // Back-pressure: first result held, second op stalls.
        clear_rec();
        res_ready = 1'b0;
        push(8'h12, 8'h34, n);
        push(8'h50, 8'h05, n);
        tick(29);
        chk("t4_busy", int'(busy), 1);
        chk("t4_add_en", int'(add_en), 0);
        chk("t4_res_valid", int'(res_valid), 1);
        chk("t4_res_held", int'(res_data), 'h46);
        chk("t4_starts", start_q.size(), 2);
        chk("t4_rels", rel_q.size(), 1);
        res_ready = 1'b1;
        tick(1);
        chk("t4_res_valid2", int'(res_valid), 1);
        chk("t4_res_new", int'(res_data), 'h55);
        chk("t4_rel_en", int'(add_en), 1);
        tick(5);
        chk("t4_count", got_q.size(), 2);
        chk_got("t4_sum0", 0, 'h46);
        chk_got("t4_sum1", 1, 'h55);

        // Reset in the middle of an op with a result held and a pair queued.
        clear_rec();
        res_ready = 1'b0;
        push(8'h01, 8'h01, n);
        push(8'h02, 8'h02, n);
        push(8'h03, 8'h03, n);
        tick(15);
        chk("t5_pre_rv", int'(res_valid), 1);
        chk("t5_pre_level", int'(fifo_level), 1);
        chk("t5_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_add_en", int'(add_en), 0);
        chk("t5_add_a", int'(add_a), 0);
        chk("t5_add_b", int'(add_b), 0);
        chk("t5_res_valid", int'(res_valid), 0);
        chk("t5_res_data", int'(res_data), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_level", int'(fifo_level), 0);
        tick(2);
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick(3);
        chk("t5_post_level", int'(fifo_level), 0);
        chk("t5_post_busy", int'(busy), 0);
        clear_rec();
        push(8'h11, 8'h22, n);
        tick(16);
        chk("t5_count", got_q.size(), 1);
        chk_got("t5_sum", 0, 'h33);

        // Push and pop on the same edge at level 3.
        clear_rec();
        push(8'h21, 8'h01, n);
        push(8'h02, 8'h03, n);
        push(8'h04, 8'h05, n);
        push(8'h06, 8'h07, n);
        guard = 0;
        while (busy && guard < 40) begin
            tick(1);
            guard++;
        end
        chk("t6_idle_reached", int'(busy), 0);
        chk("t6_level_pre", int'(fifo_level), 3);
        push(8'h08, 8'h09, m);
        chk("t6_level_post", int'(fifo_level), 3);
        chk("t6_add_en", int'(add_en), 1);
        chk("t6_head_a", int'(add_a), 'h02);
        chk("t6_head_b", int'(add_b), 'h03);
        tick(60);
        chk("t6_count", got_q.size(), 5);
        chk_got("t6_sum0", 0, 'h22);
        chk_got("t6_sum1", 1, 'h05);
        chk_got("t6_sum2", 2, 'h09);
        chk_got("t6_sum3", 3, 'h0D);
        chk_got("t6_sum4", 4, 'h11);

        chk("end_pend", pend_q.size(), 0);
        chk("end_iss", iss_q.size(), 0);
        chk("end_res", res_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/add_serial_ctrl.md
Name: add_serial_ctrl

Overview:
- Upstream sequencer for the 8-bit bit-serial adder `add_serial`.
- Buffers operand pairs in a small FIFO and issues each pair to the adder with an `en` pulse.
- Waits a fixed latency, captures the 8-bit result, then sends a second `en` pulse to return the adder from DONE to IDLE.
- Presents results on a valid/ready output port with back-pressure.

Parameters:
- WIDTH, 8, operand/result width; must match the adder.
- DEPTH, 4, operand FIFO entries (power of two, ≥2).
- ADD_LAT, 9, cycles from the cycle `add_en` is high (start) to the first cycle `add_out` holds the final sum; adder is then in DONE.
- CNT_W, 4, latency counter width; requires ADD_LAT < 2^CNT_W.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset; the adder's rst is driven from the same source, inverted.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept; equals !full.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- add_en  output  1  registered enable to adder `en`.
- add_a  output  WIDTH  registered operand A to adder.
- add_b  output  WIDTH  registered operand B to adder.
- add_out  input  WIDTH  adder `out`.
- res_valid  output  1  result register holds unread sum.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  captured sum.
- busy  output  1  FSM not in S_IDLE.
- fifo_level  output  log2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FSM goes to S_IDLE and the FIFO is emptied (fifo_level=0).
  - add_en=0, add_a=0, add_b=0, res_valid=0, res_data=0, cnt=0, busy=0.
  - Reset mid-operation abandons the in-flight op; no partial result is emitted.
- FIFO:
  - Push when in_valid && in_ready.
  - Pop only in the S_IDLE→S_RUN transition.
  - No pass-through: an empty FIFO needs one cycle before its head can issue.
  - When full, in_ready=0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves the level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: S_IDLE, S_RUN, S_REL.
- S_IDLE:
  - If fifo_level>0: add_a/add_b<=head, add_en<=1, cnt<=0, pop, next S_RUN.
  - Otherwise add_en stays 0.
- S_RUN:
  - add_en<=0 at the first edge; cnt increments each cycle.
  - cnt=k during the k-th cycle after start; the start cycle has cnt=0.
  - When cnt==ADD_LAT and the slot is free (res_valid==0 || res_ready==1): res_data<=add_out, res_valid<=1, add_en<=1, next S_REL.
  - When cnt==ADD_LAT and the slot is occupied: hold in S_RUN, cnt saturates at ADD_LAT, add_en stays 0. The adder waits in DONE with add_out stable.
- S_REL:
  - add_en is high for exactly this one cycle (adder DONE→IDLE).
  - At the edge: add_en<=0, next S_IDLE.
- Cycle accounting: minimum issue-to-issue interval is ADD_LAT+3 cycles (12 at default).
  - Start cycle t.
  - Capture edge at end of t+ADD_LAT.
  - S_REL cycle t+ADD_LAT+1.
  - S_IDLE cycle t+ADD_LAT+2.
  - Next start cycle t+ADD_LAT+3.
- Result port:
  - res_valid clears on res_valid && res_ready unless a capture happens on the same edge; then it stays 1 with the new data.
  - res_data is stable while res_valid && !res_ready.
- add_en is never high on two consecutive cycles, and never high while in S_RUN with cnt>0.
- Arithmetic: the controller does no arithmetic on the data path. The sum is modulo 2^WIDTH and carry-out is not exported.
- busy=1 in S_RUN and S_REL.

Test Plan:
- Push (0x35,0x4A) into an idle block → add_en high 1 cycle after push+1, then again exactly ADD_LAT+1 cycles later; res_valid rises at t+ADD_LAT+1 with res_data=0x7F.
- Push (0xFF,0x01) → res_data=0x00, carry dropped; push (0x80,0x80) → res_data=0x00.
- Four back-to-back pushes (0x01,0x02),(0x10,0x20),(0x7F,0x01),(0xAA,0x55) with res_ready=1:
  - fifo_level reaches 4 and in_ready=0 on the fifth offer.
  - Results are 0x03,0x30,0x80,0xFF in order, starts spaced 12 cycles apart.
- res_ready=0 with two queued ops:
  - The first result is held.
  - The second op stalls in S_RUN with cnt=9 and no add_en.
  - Raising res_ready releases the capture on that edge; no result is lost or duplicated.
- Assert rst_n=0 at cnt=4 of an op → all outputs return to reset values immediately; after release the FIFO is empty and the next pushed pair (0x11,0x22) yields 0x33.
- Push in the same cycle the FIFO pops at level 3 → level stays 3, with no overwrite of the head entry.
